// File: rtl/int_sequencer.sv
// rtl/int_sequencer.sv - interrupt / soft-reset sequencer: drain, push return PC, fetch vector, load PC.
// Optional feature macro: INTR_EDGE_EN (edge-triggered interrupt capture; level-triggered when undefined).
module int_sequencer #(
   parameter int                ADDR_W       = 8,
   parameter int                DATA_W       = 8,
   parameter int                FLAG_W       = 4,
   parameter logic [ADDR_W-1:0] RST_VEC_ADDR = 8'h00,
   parameter logic [ADDR_W-1:0] INT_VEC_ADDR = 8'h01
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reset_signal,
   input  logic              intr_signal,
   input  logic              pipe_safe,
   input  logic [ADDR_W-1:0] ret_pc,
   input  logic [FLAG_W-1:0] flags_in,
   input  logic              rti_exec,
   output logic              push_req,
   output logic [DATA_W-1:0] push_data,
   input  logic              push_gnt,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall,
   output logic              flush,
   output logic              pc_we,
   output logic [ADDR_W-1:0] pc_next,
   output logic              is_hardware_int,
   output logic              flags_restore,
   output logic [FLAG_W-1:0] flags_shadow
);

   typedef enum logic [2:0] {RHOLD, IDLE, DRAIN, SAVE, VEC, LOAD} state_t;

   state_t            state, state_nxt;
   logic              kind, kind_nxt;   // 1 = interrupt sequence, 0 = reset sequence
   logic              pend, in_isr;
   logic              req_set, enter_save;
   logic [ADDR_W-1:0] ret_reg;
   logic [DATA_W-1:0] vec_reg;

`ifdef INTR_EDGE_EN
   logic intr_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) intr_q <= 1'b0;
      else      intr_q <= intr_signal;
   end

   assign req_set = intr_signal & ~intr_q;
`else
   assign req_set = intr_signal;
`endif

   always_comb begin
      state_nxt = state;
      kind_nxt  = kind;
      if (reset_signal) begin
         state_nxt = RHOLD;
         kind_nxt  = 1'b0;
      end else begin
         case (state)
            RHOLD: begin
               state_nxt = VEC;
               kind_nxt  = 1'b0;
            end
            IDLE: if (pend && !in_isr) begin
               kind_nxt  = 1'b1;
               state_nxt = pipe_safe ? SAVE : DRAIN;
            end
            DRAIN:   if (pipe_safe) state_nxt = SAVE;
            SAVE:    if (push_gnt)  state_nxt = VEC;
            VEC:     if (mem_gnt)   state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = RHOLD;
         endcase
      end
   end

   assign enter_save = (state_nxt == SAVE) && (state != SAVE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= RHOLD;
         kind          <= 1'b0;
         pend          <= 1'b0;
         in_isr        <= 1'b0;
         ret_reg       <= '0;
         vec_reg       <= '0;
         flags_shadow  <= '0;
         flags_restore <= 1'b0;
      end else begin
         state         <= state_nxt;
         kind          <= kind_nxt;
         flags_restore <= rti_exec & in_isr & ~reset_signal;

         // A request arriving on the SAVE-entry edge stays pending rather than being lost.
         if (reset_signal)    pend <= 1'b0;
         else if (req_set)    pend <= 1'b1;
         else if (enter_save) pend <= 1'b0;

         if (reset_signal)    in_isr <= 1'b0;
         else if (enter_save) in_isr <= 1'b1;
         else if (rti_exec)   in_isr <= 1'b0;

         if (enter_save) begin
            ret_reg      <= ret_pc;
            flags_shadow <= flags_in;
         end

         if (state == VEC && mem_gnt && !reset_signal) vec_reg <= mem_rdata;
      end
   end

   assign push_req        = (state == SAVE);
   assign push_data       = push_req ? DATA_W'(ret_reg) : '0;
   assign mem_req         = (state == VEC);
   assign mem_addr        = !mem_req ? '0 : (kind ? INT_VEC_ADDR : RST_VEC_ADDR);
   assign pc_we           = (state == LOAD);
   assign pc_next         = pc_we ? ADDR_W'(vec_reg) : '0;
   assign stall           = (state == RHOLD) || (state == SAVE) || (state == VEC) || (state == LOAD);
   assign flush           = stall;
   assign is_hardware_int = kind && ((state == DRAIN) || (state == SAVE) ||
                                     (state == VEC)   || (state == LOAD));

endmodule

// File: tb/tb_int_sequencer.sv
// tb/tb_int_sequencer.sv - directed self-checking bench for int_sequencer.
module tb_int_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       reset_signal, intr_signal, pipe_safe, rti_exec;
   logic [7:0] ret_pc;
   logic [3:0] flags_in;
   logic       push_req, push_gnt, mem_req, mem_gnt;
   logic [7:0] push_data, mem_addr, mem_rdata, pc_next;
   logic       stall, flush, pc_we, is_hardware_int, flags_restore;
   logic [3:0] flags_shadow;

   int         checks = 0;
   int         errors = 0;
   int         push_dly = 0, mem_dly = 0;
   int         push_cnt = 0, mem_cnt = 0;
   logic [7:0] vec0 = 8'h02, vec1 = 8'hE0;

   always #5 clk = ~clk;

   // Stack and memory responders with configurable grant latency.
   assign push_gnt  = push_req && (push_cnt >= push_dly);
   assign mem_gnt   = mem_req && (mem_cnt >= mem_dly);
   assign mem_rdata = (mem_addr == 8'h00) ? vec0 : (mem_addr == 8'h01) ? vec1 : 8'h55;

   always @(posedge clk) begin
      push_cnt <= (push_req && !push_gnt) ? push_cnt + 1 : 0;
      mem_cnt  <= (mem_req && !mem_gnt) ? mem_cnt + 1 : 0;
   end

   int_sequencer dut (
      .clk(clk), .rst(rst), .reset_signal(reset_signal), .intr_signal(intr_signal),
      .pipe_safe(pipe_safe), .ret_pc(ret_pc), .flags_in(flags_in), .rti_exec(rti_exec),
      .push_req(push_req), .push_data(push_data), .push_gnt(push_gnt),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
      .stall(stall), .flush(flush), .pc_we(pc_we), .pc_next(pc_next),
      .is_hardware_int(is_hardware_int), .flags_restore(flags_restore),
      .flags_shadow(flags_shadow)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_rti;
      rti_exec = 1'b1;
      tick();
      rti_exec = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      rst = 1'b0; reset_signal = 1'b0; intr_signal = 1'b0; pipe_safe = 1'b1;
      rti_exec = 1'b0; ret_pc = 8'h00; flags_in = 4'h0;
      repeat (3) tick();
      checks++; if (stall !== 1'b1 || flush !== 1'b1) begin errors++; $display("FAIL rst_stall_flush: got %b%b exp 11", stall, flush); end
      checks++; if ({push_req, mem_req, pc_we, is_hardware_int, flags_restore} !== 5'b0) begin errors++; $display("FAIL rst_ctrl_outs: got %b exp 00000", {push_req, mem_req, pc_we, is_hardware_int, flags_restore}); end
      checks++; if ({push_data, mem_addr, pc_next, flags_shadow} !== 28'h0) begin errors++; $display("FAIL rst_data_outs: got %h exp 0", {push_data, mem_addr, pc_next, flags_shadow}); end
      rst = 1'b1;
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h00 || stall !== 1'b1 || pc_we !== 1'b0) begin errors++; $display("FAIL pwr_vec: got req=%b addr=%h stall=%b we=%b exp 1 00 1 0", mem_req, mem_addr, stall, pc_we); end
      tick();
      checks++; if (pc_we !== 1'b1 || pc_next !== 8'h02 || stall !== 1'b1) begin errors++; $display("FAIL pwr_load: got we=%b pc=%h stall=%b exp 1 02 1", pc_we, pc_next, stall); end
      tick();
      checks++; if (pc_we !== 1'b0 || stall !== 1'b0 || is_hardware_int !== 1'b0) begin errors++; $display("FAIL pwr_idle: got we=%b stall=%b hw=%b exp 0 0 0", pc_we, stall, is_hardware_int); end
   endtask

   task automatic test_interrupt;
      ret_pc = 8'h0F; flags_in = 4'b1010; pipe_safe = 1'b1; intr_signal = 1'b1;
      tick();
      intr_signal = 1'b0;
      checks++; if (is_hardware_int !== 1'b0 || push_req !== 1'b0) begin errors++; $display("FAIL int_edge0: got hw=%b push=%b exp 0 0", is_hardware_int, push_req); end
      tick();
      flags_in = 4'b0000; ret_pc = 8'h77;
      checks++; if (push_req !== 1'b1 || push_data !== 8'h0F || stall !== 1'b1 || is_hardware_int !== 1'b1) begin errors++; $display("FAIL int_save: got push=%b data=%h stall=%b hw=%b exp 1 0f 1 1", push_req, push_data, stall, is_hardware_int); end
      checks++; if (flags_shadow !== 4'b1010) begin errors++; $display("FAIL int_shadow: got %b exp 1010", flags_shadow); end
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h01 || push_req !== 1'b0) begin errors++; $display("FAIL int_vec: got req=%b addr=%h push=%b exp 1 01 0", mem_req, mem_addr, push_req); end
      tick();
      checks++; if (pc_we !== 1'b1 || pc_next !== 8'hE0) begin errors++; $display("FAIL int_load: got we=%b pc=%h exp 1 e0", pc_we, pc_next); end
      tick();
      checks++; if (pc_we !== 1'b0 || stall !== 1'b0 || flags_shadow !== 4'b1010) begin errors++; $display("FAIL int_idle: got we=%b stall=%b shadow=%b exp 0 0 1010", pc_we, stall, flags_shadow); end
      rti_exec = 1'b1;
      tick();
      rti_exec = 1'b0;
      checks++; if (flags_restore !== 1'b1) begin errors++; $display("FAIL int_restore_pulse: got %b exp 1", flags_restore); end
      tick();
      checks++; if (flags_restore !== 1'b0) begin errors++; $display("FAIL int_restore_end: got %b exp 0", flags_restore); end
   endtask

   task automatic test_drain;
      ret_pc = 8'h21; pipe_safe = 1'b0; intr_signal = 1'b1;
      tick();
      intr_signal = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (stall !== 1'b0 || flush !== 1'b0 || push_req !== 1'b0 || is_hardware_int !== 1'b1) begin errors++; $display("FAIL drain_hold[%0d]: got stall=%b flush=%b push=%b hw=%b exp 0 0 0 1", i, stall, flush, push_req, is_hardware_int); end
      end
      pipe_safe = 1'b1;
      tick();
      checks++; if (push_req !== 1'b1 || push_data !== 8'h21 || stall !== 1'b1) begin errors++; $display("FAIL drain_save: got push=%b data=%h stall=%b exp 1 21 1", push_req, push_data, stall); end
      repeat (3) tick();
      do_rti();
   endtask

   task automatic test_backpressure;
      int n_push, n_mem, n_we, bad;
      n_push = 0; n_mem = 0; n_we = 0; bad = 0;
      push_dly = 3; mem_dly = 2; vec1 = 8'hA5;
      ret_pc = 8'h3C; pipe_safe = 1'b1; intr_signal = 1'b1;
      tick();
      intr_signal = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         ret_pc = 8'h00;
         if (push_req) begin n_push++; if (push_data !== 8'h3C) bad++; end
         if (mem_req)  begin n_mem++;  if (mem_addr !== 8'h01) bad++; end
         if (pc_we)    begin n_we++;   if (pc_next !== 8'hA5) bad++; end
      end
      checks++; if (n_push != 4) begin errors++; $display("FAIL bp_push_cycles: got %0d exp 4", n_push); end
      checks++; if (n_mem != 3) begin errors++; $display("FAIL bp_mem_cycles: got %0d exp 3", n_mem); end
      checks++; if (n_we != 1) begin errors++; $display("FAIL bp_pc_we_count: got %0d exp 1", n_we); end
      checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable_values: got %0d unstable cycles exp 0", bad); end
      push_dly = 0; mem_dly = 0; vec1 = 8'hE0;
      do_rti();
   endtask

   task automatic test_nesting;
      ret_pc = 8'h40; pipe_safe = 1'b1; intr_signal = 1'b1;
      tick();
      intr_signal = 1'b0;
      repeat (4) tick();
      intr_signal = 1'b1;
      tick();
      intr_signal = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (push_req !== 1'b0 || is_hardware_int !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL nest_wait[%0d]: got push=%b hw=%b stall=%b exp 0 0 0", i, push_req, is_hardware_int, stall); end
      end
      rti_exec = 1'b1;
      tick();
      rti_exec = 1'b0;
      checks++; if (flags_restore !== 1'b1 || push_req !== 1'b0) begin errors++; $display("FAIL nest_rti: got restore=%b push=%b exp 1 0", flags_restore, push_req); end
      tick();
      checks++; if (push_req !== 1'b1 || flags_restore !== 1'b0) begin errors++; $display("FAIL nest_second: got push=%b restore=%b exp 1 0", push_req, flags_restore); end
      repeat (3) tick();
      rti_exec = 1'b1; intr_signal = 1'b1;
      tick();
      rti_exec = 1'b0; intr_signal = 1'b0;
      tick();
      checks++; if (push_req !== 1'b1) begin errors++; $display("FAIL rti_coincident: got push=%b exp 1", push_req); end
      repeat (3) tick();
      do_rti();
   endtask

   task automatic test_abort;
      mem_dly = 5; pipe_safe = 1'b1; intr_signal = 1'b1;
      tick();
      intr_signal = 1'b0;
      repeat (2) tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h01) begin errors++; $display("FAIL abort_in_vec: got req=%b addr=%h exp 1 01", mem_req, mem_addr); end
      reset_signal = 1'b1;
      tick();
      checks++; if (mem_req !== 1'b0 || stall !== 1'b1 || flush !== 1'b1 || is_hardware_int !== 1'b0) begin errors++; $display("FAIL abort_rhold: got req=%b stall=%b flush=%b hw=%b exp 0 1 1 0", mem_req, stall, flush, is_hardware_int); end
      tick();
      checks++; if (mem_req !== 1'b0 || pc_we !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL abort_hold: got req=%b we=%b stall=%b exp 0 0 1", mem_req, pc_we, stall); end
      reset_signal = 1'b0; mem_dly = 0;
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h00 || is_hardware_int !== 1'b0) begin errors++; $display("FAIL abort_rvec: got req=%b addr=%h hw=%b exp 1 00 0", mem_req, mem_addr, is_hardware_int); end
      tick();
      checks++; if (pc_we !== 1'b1 || pc_next !== 8'h02) begin errors++; $display("FAIL abort_rload: got we=%b pc=%h exp 1 02", pc_we, pc_next); end
      tick();
      ret_pc = 8'h11; intr_signal = 1'b1;
      tick();
      intr_signal = 1'b0;
      tick();
      checks++; if (push_req !== 1'b1 || push_data !== 8'h11) begin errors++; $display("FAIL abort_isr_cleared: got push=%b data=%h exp 1 11", push_req, push_data); end
      repeat (3) tick();
      do_rti();
   endtask

   initial begin
      test_reset();
      test_interrupt();
      test_drain();
      test_backpressure();
      test_nesting();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
